// File: rtl/message_scheduler.sv
// Message schedule expander: takes one 512-bit padded block and expands it into W[0..63].
// Optional build macro SCHED_TWO_WORD_EN: when defined, two words are produced per EXPAND cycle
// (24 cycles); when undefined, one word per cycle (48 cycles). W values are identical in both.
module message_scheduler (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:511]      block_in,
  input  logic              block_valid,
  output logic              block_ready,
  output logic [0:63][0:31] message_schedule,
  output logic              sched_valid,
  input  logic              sched_ready
);

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

`ifdef SCHED_TWO_WORD_EN
  localparam logic [6:0] StepT = 7'd2;
  localparam logic [6:0] LastT = 7'd62;
`else
  localparam logic [6:0] StepT = 7'd1;
  localparam logic [6:0] LastT = 7'd63;
`endif

  state_e            state_q, state_d;
  logic [6:0]        t_q, t_d;
  logic [0:63][31:0] w_q, w_d;
  // Goes high on the first edge that samples rst released; gates block_ready.
  logic              live_q;
  logic [5:0]        idx;
  logic [31:0]       word_t;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign idx    = t_q[5:0];
  assign word_t = sigma1(w_q[idx - 6'd2]) + w_q[idx - 6'd7]
                + sigma0(w_q[idx - 6'd15]) + w_q[idx - 6'd16];

`ifdef SCHED_TWO_WORD_EN
  // W[t+1] depends on W[t-1], not W[t], so both words come from stored values.
  logic [31:0] word_t1;
  assign word_t1 = sigma1(w_q[idx - 6'd1]) + w_q[idx - 6'd6]
                 + sigma0(w_q[idx - 6'd14]) + w_q[idx - 6'd15];
`endif

  assign block_ready      = (state_q == StIdle) && live_q;
  assign sched_valid      = (state_q == StDone);
  assign message_schedule = w_q;

  // Next-state logic: load, expand one (or two) words per cycle, hold until consumed.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    w_d     = w_q;
    unique case (state_q)
      StIdle: begin
        if (block_valid && block_ready) begin
          w_d[0:15] = block_in;
          t_d       = 7'd16;
          state_d   = StExpand;
        end
      end
      StExpand: begin
        w_d[idx] = word_t;
`ifdef SCHED_TWO_WORD_EN
        w_d[idx + 6'd1] = word_t1;
`endif
        // t parks on its last value so it never wraps past 63.
        if (t_q == LastT) begin
          state_d = StDone;
        end else begin
          t_d = t_q + StepT;
        end
      end
      StDone: begin
        if (sched_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, index and schedule registers; reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      t_q     <= 7'd16;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      w_q     <= w_d;
    end
  end

  // Release tracker so no block is accepted while reset is still asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_message_scheduler.sv
// Directed bench for message_scheduler; expected schedules come from an independent model.
module tb_message_scheduler;

`ifdef SCHED_TWO_WORD_EN
  localparam int Lat = 24;
`else
  localparam int Lat = 48;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [0:511]      block_in = '0;
  logic              block_valid = 1'b0;
  logic              block_ready;
  logic [0:63][0:31] message_schedule;
  logic              sched_valid;
  logic              sched_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  message_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .block_in         (block_in),
    .block_valid      (block_valid),
    .block_ready      (block_ready),
    .message_schedule (message_schedule),
    .sched_valid      (sched_valid),
    .sched_ready      (sched_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [0:63][31:0] ref_sched(input logic [0:511] blk);
    logic [31:0]       w [64];
    logic [0:63][31:0] r;
    logic [31:0]       s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 64; i++) r[i] = w[i];
    return r;
  endfunction

  function automatic logic [0:511] gen_block(input logic [31:0] seed);
    logic [0:511] b;
    logic [31:0]  k;
    for (int i = 0; i < 16; i++) begin
      k = 32'(i + 1);
      b[32*i +: 32] = (seed * k) ^ 32'hA5A5_5A5A;
    end
    return b;
  endfunction

  function automatic logic [0:511] abc_block();
    logic [0:511] b;
    b = '0;
    b[0:31]    = 32'h6162_6380;
    b[480:511] = 32'h0000_0018;
    return b;
  endfunction

  // Index of the first schedule word differing from exp, or -1.
  function automatic int first_bad(input logic [0:63][31:0] exp);
    for (int i = 0; i < 64; i++) begin
      if (message_schedule[i] !== exp[i]) return i;
    end
    return -1;
  endfunction

  // Waits for block_ready, then presents blk for exactly one accepting edge.
  task automatic accept(input logic [0:511] blk);
    int n;
    n = 0;
    block_in = blk;
    while (block_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (block_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_ready: block_ready=%b required 1", block_ready);
    end
    block_valid = 1'b1;
    @(posedge clk); #1;
    block_valid = 1'b0;
  endtask

  // Counts cycles until sched_valid (bounded) and how often block_ready was seen high.
  task automatic wait_done(output int cyc, output int rdy_hi);
    cyc = 0;
    rdy_hi = 0;
    while (sched_valid !== 1'b1 && cyc < 200) begin
      if (block_ready !== 1'b0) rdy_hi++;
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_reset();
    logic [0:63][31:0] zero;
    int bad;
    zero = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (block_ready !== 1'b0) begin
      miscompares++; $display("FAIL rst_block_ready: got %b required 0", block_ready);
    end
    vectors++;
    if (sched_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_sched_valid: got %b required 0", sched_valid);
    end
    bad = first_bad(zero);
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL rst_w_zero: W[%0d]=%h required 0", bad, message_schedule[bad]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (block_ready !== 1'b1) begin
      miscompares++; $display("FAIL rst_release_ready: got %b required 1", block_ready);
    end
  endtask

  task automatic test_abc();
    logic [0:63][31:0] exp;
    int cyc, rdy_hi, bad;
    exp = ref_sched(abc_block());
    accept(abc_block());
    wait_done(cyc, rdy_hi);
    vectors++;
    if (cyc != Lat) begin
      miscompares++; $display("FAIL abc_latency: got %0d required %0d", cyc, Lat);
    end
    vectors++;
    if (message_schedule[16] !== 32'h6162_6380) begin
      miscompares++; $display("FAIL abc_w16: got %h required 61626380", message_schedule[16]);
    end
    vectors++;
    if (message_schedule[17] !== 32'h000F_0000) begin
      miscompares++; $display("FAIL abc_w17: got %h required 000f0000", message_schedule[17]);
    end
    vectors++;
    if (message_schedule[63] !== 32'h12B1_EDEB) begin
      miscompares++; $display("FAIL abc_w63: got %h required 12b1edeb", message_schedule[63]);
    end
    bad = first_bad(exp);
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL abc_sched: W[%0d]=%h required %h", bad, message_schedule[bad], exp[bad]);
    end
    sched_ready = 1'b1;
    @(posedge clk); #1;
    sched_ready = 1'b0;
    vectors++;
    if (block_ready !== 1'b1 || sched_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abc_release: ready=%b valid=%b required 1/0", block_ready, sched_valid);
    end
  endtask

  task automatic test_zero();
    logic [0:63][31:0] zero;
    int cyc, rdy_hi, bad, done_rdy;
    zero = '0;
    accept('0);
    wait_done(cyc, rdy_hi);
    vectors++;
    if (cyc != Lat) begin
      miscompares++; $display("FAIL zero_latency: got %0d required %0d", cyc, Lat);
    end
    vectors++;
    if (rdy_hi != 0) begin
      miscompares++; $display("FAIL zero_expand_ready: ready high %0d cycles required 0", rdy_hi);
    end
    bad = first_bad(zero);
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL zero_sched: W[%0d]=%h required 0", bad, message_schedule[bad]);
    end
    done_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      if (block_ready !== 1'b0) done_rdy++;
      @(posedge clk); #1;
    end
    vectors++;
    if (done_rdy != 0) begin
      miscompares++; $display("FAIL zero_done_ready: ready high %0d cycles required 0", done_rdy);
    end
    sched_ready = 1'b1;
    @(posedge clk); #1;
    sched_ready = 1'b0;
  endtask

  task automatic test_hold();
    logic [0:63][31:0] exp;
    int cyc, rdy_hi, bad, bad_cycles;
    exp = ref_sched(gen_block(32'h9E37_79B9));
    accept(gen_block(32'h9E37_79B9));
    wait_done(cyc, rdy_hi);
    bad_cycles = 0;
    for (int k = 0; k < 10; k++) begin
      if (sched_valid !== 1'b1 || block_ready !== 1'b0 || first_bad(exp) >= 0) bad_cycles++;
      if (k == 4) begin
        block_in    = gen_block(32'h0BAD_F00D);
        block_valid = 1'b1;
      end
      if (k == 5) block_valid = 1'b0;
      @(posedge clk); #1;
    end
    block_valid = 1'b0;
    vectors++;
    if (bad_cycles != 0) begin
      miscompares++; $display("FAIL hold_stable: %0d unstable cycles required 0", bad_cycles);
    end
    sched_ready = 1'b1;
    @(posedge clk); #1;
    sched_ready = 1'b0;
    vectors++;
    if (block_ready !== 1'b1 || sched_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_release: ready=%b valid=%b required 1/0", block_ready, sched_valid);
    end
    bad = first_bad(exp);
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL hold_sched: W[%0d]=%h required %h", bad, message_schedule[bad], exp[bad]);
    end
    @(posedge clk); #1;
    vectors++;
    if (block_ready !== 1'b1) begin
      miscompares++; $display("FAIL hold_no_accept: ready=%b required 1", block_ready);
    end
  endtask

  task automatic test_mid_reset();
    logic [0:63][31:0] zero;
    int cyc, rdy_hi, bad;
    zero = '0;
    accept(gen_block(32'h1357_9BDF));
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    bad = first_bad(zero);
    vectors++;
    if (sched_valid !== 1'b0 || bad >= 0) begin
      miscompares++;
      $display("FAIL midrst_clear: valid=%b first nonzero W=%0d required 0/-1", sched_valid, bad);
    end
    repeat (3) @(posedge clk);
    #1;
    bad = first_bad(zero);
    vectors++;
    if (sched_valid !== 1'b0 || block_ready !== 1'b0 || bad >= 0) begin
      miscompares++;
      $display("FAIL midrst_hold: valid=%b ready=%b bad=%0d required 0/0/-1",
               sched_valid, block_ready, bad);
    end
    rst = 1'b1;
    accept(abc_block());
    wait_done(cyc, rdy_hi);
    vectors++;
    if (cyc != Lat) begin
      miscompares++; $display("FAIL midrst_latency: got %0d required %0d", cyc, Lat);
    end
    vectors++;
    if (message_schedule[63] !== 32'h12B1_EDEB) begin
      miscompares++; $display("FAIL midrst_w63: got %h required 12b1edeb", message_schedule[63]);
    end
    sched_ready = 1'b1;
    @(posedge clk); #1;
    sched_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [0:63][31:0] exp_a, exp_b;
    int cyc, rdy_hi, bad, n;
    exp_a = ref_sched(gen_block(32'hDEAD_BEEF));
    exp_b = ref_sched(gen_block(32'h0123_4567));
    sched_ready = 1'b1;
    block_in = gen_block(32'hDEAD_BEEF);
    n = 0;
    while (block_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    block_valid = 1'b1;
    @(posedge clk); #1;
    block_in = gen_block(32'h0123_4567);
    wait_done(cyc, rdy_hi);
    vectors++;
    if (cyc != Lat) begin
      miscompares++; $display("FAIL b2b_latency_a: got %0d required %0d", cyc, Lat);
    end
    bad = first_bad(exp_a);
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL b2b_sched_a: W[%0d]=%h required %h", bad, message_schedule[bad], exp_a[bad]);
    end
    @(posedge clk); #1;
    vectors++;
    if (block_ready !== 1'b1 || sched_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ready_return: ready=%b valid=%b required 1/0", block_ready, sched_valid);
    end
    @(posedge clk); #1;
    block_valid = 1'b0;
    vectors++;
    if (block_ready !== 1'b0) begin
      miscompares++; $display("FAIL b2b_accept_b: ready=%b required 0", block_ready);
    end
    wait_done(cyc, rdy_hi);
    vectors++;
    if (cyc != Lat) begin
      miscompares++; $display("FAIL b2b_latency_b: got %0d required %0d", cyc, Lat);
    end
    bad = first_bad(exp_b);
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL b2b_sched_b: W[%0d]=%h required %h", bad, message_schedule[bad], exp_b[bad]);
    end
    @(posedge clk); #1;
    sched_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_zero();
    test_hold();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
